// File: rtl/apb_rr_requester_arbiter.sv
// apb_rr_requester_arbiter: round-robin front end sharing one APB completer
// between NUM_REQ local requesters. A three-state requester FSM drives the
// APB bus; completion (normal, PERROR or PREADY timeout) is returned as a
// one-cycle rsp_valid pulse to the requester that owned the transfer.
//
// Handshake: a command on requester i is taken on the rising edge where
// req_valid[i] & req_ready[i] are both high. req_ready is one-hot and only
// asserted in IDLE for the round-robin winner. The requester keeps its
// command fields stable until that edge. rsp_valid[i] is a single-cycle
// pulse with no back-pressure; rsp_rdata/rsp_error are valid with it and
// hold until the next completion.
module apb_rr_requester_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_strb,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_error,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [DATA_W-1:0]            PRDATA,
  input  logic                         PREADY,
  input  logic                         PERROR,
  output logic [1:0]                   dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 pwrite_q;
  logic [ADDR_W-1:0]    paddr_q;
  logic [DATA_W-1:0]    pwdata_q;
  logic [STRB_W-1:0]    pstrb_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 rsp_error_q;

  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W:0]       cand_w;
  logic                 accept;
  logic                 xfer_done;
  logic                 xfer_err;
  logic [DATA_W-1:0]    xfer_rdata;

  // Round-robin search: first valid requester at or after ptr+1, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand_w  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_w = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (cand_w >= (PTR_W+1)'(NUM_REQ)) cand_w = cand_w - (PTR_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[cand_w[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_w[PTR_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_any) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (xfer_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant, completion decode (PREADY wins over timeout).
  always_comb begin
    req_ready  = '0;
    accept     = 1'b0;
    xfer_done  = 1'b0;
    xfer_err   = 1'b0;
    xfer_rdata = '0;
    if (state_q == ST_IDLE && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
      accept             = 1'b1;
    end
    if (state_q == ST_ACCESS) begin
      if (PREADY) begin
        xfer_done  = 1'b1;
        xfer_err   = PERROR;
        xfer_rdata = pwrite_q ? '0 : PRDATA;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        xfer_done = 1'b1;
        xfer_err  = 1'b1;
      end
    end
  end

  // Datapath: command latch, pointer, ACCESS counter and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        ptr_q    <= gnt_idx;
        pwrite_q <= req_write[gnt_idx];
        paddr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
        pwdata_q <= req_wdata[gnt_idx*DATA_W +: DATA_W];
        pstrb_q  <= req_strb[gnt_idx*STRB_W +: STRB_W];
      end
      if (state_q == ST_SETUP) cnt_q <= '0;
      else if (state_q == ST_ACCESS && !xfer_done) cnt_q <= cnt_q + CNT_W'(1);
      if (xfer_done) begin
        rsp_valid_q[ptr_q] <= 1'b1;
        rsp_rdata_q        <= xfer_rdata;
        rsp_error_q        <= xfer_err;
      end
    end
  end

  assign PSEL        = (state_q != ST_IDLE);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_rr_requester_arbiter.sv
// Directed bench for apb_rr_requester_arbiter with a 16x32 completer model.
module tb_apb_rr_requester_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR*DW/8-1:0] req_strb = '0;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW/8-1:0]   PSTRB;
  logic [DW-1:0]     PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PERROR = 1'b0;
  logic [1:0]        dbg_state_o;

  apb_rr_requester_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PERROR(PERROR), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [35:0]  exp_q[$];          // {idx[2:0], err, rdata[31:0]}
  logic [2:0]   gnt_log[$];
  int unsigned  acc_cyc[NR];
  int           errors = 0;
  int           checks = 0;
  int unsigned  last_lat = 0;
  int           psel_total = 0;
  int           pen_total = 0;
  int           rsp_cnt = 0;
  int           stable_bad = 0;

  // completer model controls
  logic [31:0]  mem[16];
  int           wait_states = 0;
  bit           hang = 0;
  bit           stray = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- completer model ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (!hang && wcnt >= wait_states) begin
          PREADY = 1'b1;
          PERROR = (PADDR >= 32'd16);
          PRDATA = mem[PADDR[3:0]];
          if (PWRITE && !PERROR)
            for (int b = 0; b < 4; b++)
              if (PSTRB[b]) mem[PADDR[3:0]][b*8 +: 8] = PWDATA[b*8 +: 8];
          wcnt = 0;
        end else begin
          PREADY = 1'b0;
          PERROR = 1'b0;
          wcnt++;
        end
      end else begin
        PREADY = stray;
        PERROR = stray;
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [35:0] e;
    logic [2:0]  ei;
    logic [3:0]  oh;
    logic [AW+DW+DW/8:0] setup_cmd;
    setup_cmd = '0;
    forever begin
      @(negedge PCLK);
      if (PSEL) psel_total++;
      if (PENABLE) pen_total++;
      if (PSEL && !PENABLE) setup_cmd = {PWRITE, PADDR, PWDATA, PSTRB};
      if (PSEL && PENABLE && ({PWRITE, PADDR, PWDATA, PSTRB} != setup_cmd)) stable_bad++;
      if (rsp_valid != '0) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
        end else begin
          e  = exp_q.pop_front();
          ei = e[35:33];
          oh = 4'b0001 << ei;
          chk("rsp_valid_onehot", 64'(rsp_valid), 64'(oh));
          chk("rsp_error", 64'(rsp_error), 64'(e[32]));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
          last_lat = cyc - acc_cyc[ei];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int idx, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input bit expect_rsp, input logic err, input logic [31:0] rd);
    int budget;
    @(negedge PCLK);
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wdata;
    req_strb[idx*4 +: 4]    = strb;
    budget = 0;
    #1;
    while (!req_ready[idx] && budget < 1000) begin
      @(negedge PCLK);
      #1;
      budget++;
    end
    if (!req_ready[idx]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d never granted", idx);
    end else begin
      gnt_log.push_back(3'(idx));
      acc_cyc[idx] = cyc;
      if (expect_rsp) exp_q.push_back({3'(idx), err, rd});
    end
    @(posedge PCLK);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || dbg_state_o != 2'd0) && b < 200) begin
      @(negedge PCLK);
      b++;
    end
    if (b >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timed out with %0d responses outstanding", exp_q.size());
    end
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, e0, r0, wb;
    logic [2:0] rr_exp[5];
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd3; rr_exp[4] = 3'd0;

    repeat (3) @(negedge PCLK);
    #1;
    chk("reset_psel", 64'(PSEL), 0);
    chk("reset_penable", 64'(PENABLE), 0);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_paddr", 64'(PADDR), 0);
    chk("reset_state", 64'(dbg_state_o), 0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // 1. single write, PREADY in first ACCESS cycle
    wait_states = 0;
    p0 = psel_total; e0 = pen_total;
    issue(0, 1'b1, 32'd3, 32'hA5A5_1234, 4'hF, 1, 1'b0, 32'h0);
    wait_done();
    chk("t1_psel_cycles", 64'(psel_total - p0), 2);
    chk("t1_penable_cycles", 64'(pen_total - e0), 1);
    chk("t1_latency", 64'(last_lat), 3);

    // 2. read-back with 16 wait states
    wait_states = 16;
    e0 = pen_total;
    issue(1, 1'b0, 32'd3, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_1234);
    wait_done();
    chk("t2_penable_cycles", 64'(pen_total - e0), 17);
    chk("t2_latency", 64'(last_lat), 19);
    wait_states = 0;

    // PREADY/PERROR outside ACCESS are ignored
    r0 = rsp_cnt;
    stray = 1'b1;
    repeat (5) @(negedge PCLK);
    stray = 1'b0;
    @(negedge PCLK);
    #1;
    chk("stray_state", 64'(dbg_state_o), 0);
    chk("stray_no_rsp", 64'(rsp_cnt - r0), 0);

    // 4. out-of-range write errors back to requester 3 only
    issue(3, 1'b1, 32'd20, 32'hDEAD_BEEF, 4'hF, 1, 1'b1, 32'h0);
    wait_done();

    // 3. round robin with all four requesting
    gnt_log.delete();
    fork
      begin
        issue(0, 1'b1, 32'd4, 32'h1111_1111, 4'hF, 1, 1'b0, 32'h0);
        issue(0, 1'b0, 32'd6, 32'h0, 4'h0, 1, 1'b0, 32'h0000_3333);
      end
      issue(1, 1'b1, 32'd5, 32'h2222_2222, 4'hF, 1, 1'b0, 32'h0);
      issue(2, 1'b1, 32'd6, 32'h3333_3333, 4'h3, 1, 1'b0, 32'h0);
      issue(3, 1'b1, 32'd7, 32'h4444_4444, 4'hC, 1, 1'b0, 32'h0);
    join
    wait_done();
    chk("rr_grant_count", 64'(gnt_log.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < gnt_log.size()) chk($sformatf("rr_grant_%0d", i), 64'(gnt_log[i]), 64'(rr_exp[i]));
    issue(1, 1'b0, 32'd7, 32'h0, 4'h0, 1, 1'b0, 32'h4444_0000);
    wait_done();

    // 5. timeout: completer never answers
    hang = 1'b1;
    e0 = pen_total;
    issue(2, 1'b0, 32'd3, 32'h0, 4'h0, 1, 1'b1, 32'h0);
    wait_done();
    chk("t5_access_cycles", 64'(pen_total - e0), 64);
    chk("t5_latency", 64'(last_lat), 66);

    // 6. reset in the middle of ACCESS
    issue(2, 1'b0, 32'd1, 32'h0, 4'h0, 0, 1'b0, 32'h0);
    wb = 0;
    while (!PENABLE && wb < 20) begin
      @(negedge PCLK);
      wb++;
    end
    chk("t6_reached_access", 64'(PENABLE), 1);
    repeat (3) @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t6_psel_async", 64'(PSEL), 0);
    chk("t6_penable_async", 64'(PENABLE), 0);
    chk("t6_rsp_valid_async", 64'(rsp_valid), 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    hang = 1'b0;
    gnt_log.delete();
    fork
      issue(0, 1'b0, 32'd3, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_1234);
      issue(3, 1'b1, 32'd8, 32'h5555_5555, 4'hF, 1, 1'b0, 32'h0);
    join
    wait_done();
    chk("t6_grant_count", 64'(gnt_log.size()), 2);
    if (gnt_log.size() >= 2) begin
      chk("t6_first_grant", 64'(gnt_log[0]), 0);
      chk("t6_second_grant", 64'(gnt_log[1]), 3);
    end

    repeat (3) @(negedge PCLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    chk("access_stable", 64'(stable_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
